// File: rtl/tinyml_buf_pkg.sv
// ---------------------------------------------------------------------------
// tinyml_buf_pkg
// Shared definitions for the ping-pong tile buffer scheduler.
//   buf_state_t        - lifecycle of one buffer (EMPTY/FILLING/FULL/DRAINING)
//   DEFAULT_*          - default parameter values used by the scheduler and
//                        its interface
//   GRANT_WRITE/READ   - bit positions of the write and read requests/grants
//                        on the two-way arbiter
//   idx_width()        - width of an index into N things, never below 1 bit
// ---------------------------------------------------------------------------
package tinyml_buf_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY    = 2'd0,
        BUF_FILLING  = 2'd1,
        BUF_FULL     = 2'd2,
        BUF_DRAINING = 2'd3
    } buf_state_t;

    localparam int DEFAULT_BUFFER_COUNT     = 2;
    localparam int DEFAULT_TILE_WIDTH       = 256;
    localparam int DEFAULT_TILES_PER_BUFFER = 4;

    localparam int GRANT_WRITE = 0;
    localparam int GRANT_READ  = 1;

    // A single buffer or a single tile still needs a 1-bit index so that
    // port and counter declarations never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buffer_pingpong_sched_if.sv
// ---------------------------------------------------------------------------
// buffer_pingpong_sched_if
// Bundles the producer, consumer and buffer-file signals of the ping-pong
// scheduler.
//   producer    : in_valid, in_data, in_ready
//   consumer    : out_ready, out_valid, out_buf, out_last
//   buffer file : bf_write_enable, bf_write_data, bf_write_buffer,
//                 bf_read_enable, bf_read_buffer,
//                 bf_writing_done, bf_reading_done
// Modports:
//   master - the scheduler itself
//   slave  - the surrounding system (producer, consumer and buffer file)
// ---------------------------------------------------------------------------
interface buffer_pingpong_sched_if
    import tinyml_buf_pkg::*;
#(
    parameter int BUFFER_COUNT = DEFAULT_BUFFER_COUNT,
    parameter int TILE_WIDTH   = DEFAULT_TILE_WIDTH
);

    localparam int BUF_W = idx_width(BUFFER_COUNT);

    // producer side
    logic                  in_valid;
    logic [TILE_WIDTH-1:0] in_data;
    logic                  in_ready;

    // consumer side
    logic                  out_ready;
    logic                  out_valid;
    logic [BUF_W-1:0]      out_buf;
    logic                  out_last;

    // buffer file side
    logic                  bf_write_enable;
    logic [TILE_WIDTH-1:0] bf_write_data;
    logic [BUF_W-1:0]      bf_write_buffer;
    logic                  bf_read_enable;
    logic [BUF_W-1:0]      bf_read_buffer;
    logic                  bf_writing_done;
    logic                  bf_reading_done;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        input  out_ready,
        output out_valid,
        output out_buf,
        output out_last,
        output bf_write_enable,
        output bf_write_data,
        output bf_write_buffer,
        output bf_read_enable,
        output bf_read_buffer,
        input  bf_writing_done,
        input  bf_reading_done
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        output out_ready,
        input  out_valid,
        input  out_buf,
        input  out_last,
        input  bf_write_enable,
        input  bf_write_data,
        input  bf_write_buffer,
        input  bf_read_enable,
        input  bf_read_buffer,
        output bf_writing_done,
        output bf_reading_done
    );

endinterface

// File: rtl/rw_arbiter.sv
// ---------------------------------------------------------------------------
// rw_arbiter
// Two-request arbiter with alternating priority and a one-hot grant.
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : req[GRANT_WRITE] = write eligible, req[GRANT_READ] = read
//                eligible
//   gnt[1:0]   : one-hot grant (or zero when nothing requests)
// When both sides request, the side that did not win the most recent grant
// wins. Straight after reset the write side has priority.
// ---------------------------------------------------------------------------
module rw_arbiter
    import tinyml_buf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prefer_read_q;

    // Remember which side went last. Any grant, contended or not, counts as
    // "the last grant", so a write that went through alone still hands the
    // next contended cycle to the reader.
    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_read_q <= 1'b0;
        end else if (|gnt) begin
            prefer_read_q <= gnt[GRANT_WRITE];
        end
    end

    // Grant a lone requester outright; break a tie with the toggle.
    always_comb begin
        gnt = 2'b00;
        if (req[GRANT_WRITE] && req[GRANT_READ]) begin
            if (prefer_read_q) begin
                gnt[GRANT_READ] = 1'b1;
            end else begin
                gnt[GRANT_WRITE] = 1'b1;
            end
        end else if (req[GRANT_WRITE]) begin
            gnt[GRANT_WRITE] = 1'b1;
        end else if (req[GRANT_READ]) begin
            gnt[GRANT_READ] = 1'b1;
        end
    end

endmodule

// File: rtl/buffer_pingpong_sched.sv
// ---------------------------------------------------------------------------
// buffer_pingpong_sched
// Schedules tile writes and tile reads over BUFFER_COUNT buffers in
// ping-pong order. A producer fills one buffer at a time while a consumer
// drains earlier full buffers; at most one tile moves per cycle.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   bus         : producer / consumer / buffer-file handshake (master side)
//   full_count  : registered number of buffers currently FULL
//   idle        : registered; every buffer EMPTY and no read in flight
//   err         : sticky; buffer-file done pulses disagree with the last-tile
//                 grants issued one cycle earlier
// The buffer file shares our tile indices, so the system must reset it in
// the same cycle as this block.
// ---------------------------------------------------------------------------
module buffer_pingpong_sched
    import tinyml_buf_pkg::*;
#(
    parameter int BUFFER_COUNT     = DEFAULT_BUFFER_COUNT,
    parameter int TILE_WIDTH       = DEFAULT_TILE_WIDTH,
    parameter int TILES_PER_BUFFER = DEFAULT_TILES_PER_BUFFER
) (
    input  logic                              clk,
    input  logic                              reset,
    buffer_pingpong_sched_if.master           bus,
    output logic [$clog2(BUFFER_COUNT+1)-1:0] full_count,
    output logic                              idle,
    output logic                              err
);

    localparam int BUF_W = idx_width(BUFFER_COUNT);
    localparam int CNT_W = idx_width(TILES_PER_BUFFER);
    localparam int FC_W  = $clog2(BUFFER_COUNT + 1);

    localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(TILES_PER_BUFFER - 1);
    localparam logic [BUF_W-1:0] LAST_BUF  = BUF_W'(BUFFER_COUNT - 1);

    buf_state_t state_q [BUFFER_COUNT];
    buf_state_t state_d [BUFFER_COUNT];

    logic [BUF_W-1:0] wr_sel_q, wr_sel_d;
    logic [BUF_W-1:0] rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    logic [TILE_WIDTH-1:0] wr_data;
    logic                  wr_eligible;
    logic                  rd_eligible;
    logic                  wr_last;
    logic                  rd_last;
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  gnt_write;
    logic                  gnt_read;
    logic [FC_W-1:0]       full_d;
    logic                  all_empty_d;
    logic                  wr_last_q;
    logic                  rd_last_q;

    assign wr_data = bus.in_data;

    // A side may only compete when its target buffer is in a phase that
    // accepts that kind of access. Eligibility looks only at registered
    // state, so a buffer emptied by a read this cycle is not offered to the
    // writer until the following cycle.
    always_comb begin
        wr_eligible = bus.in_valid &&
                      ((state_q[wr_sel_q] == BUF_EMPTY) ||
                       (state_q[wr_sel_q] == BUF_FILLING));
        rd_eligible = bus.out_ready &&
                      ((state_q[rd_sel_q] == BUF_FULL) ||
                       (state_q[rd_sel_q] == BUF_DRAINING));
        wr_last     = (wr_cnt_q == LAST_TILE);
        rd_last     = (rd_cnt_q == LAST_TILE);
    end

    assign req[GRANT_WRITE] = wr_eligible;
    assign req[GRANT_READ]  = rd_eligible;

    rw_arbiter u_arbiter (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign gnt_write = gnt[GRANT_WRITE];
    assign gnt_read  = gnt[GRANT_READ];

    // State register: per-buffer phase, fill/drain targets and the tile
    // counters. Reset throws away any partial fill or drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUFFER_COUNT; i++) begin
                state_q[i] <= BUF_EMPTY;
            end
            wr_sel_q <= '0;
            rd_sel_q <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Next-state logic. The last tile of a buffer closes it (FULL after a
    // fill, EMPTY after a drain) and moves the matching pointer to the next
    // buffer in ring order. Writing FILLING/DRAINING first and overriding on
    // the last tile keeps single-tile buffers correct as well.
    always_comb begin
        state_d  = state_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;

        if (gnt_write) begin
            if (wr_last) begin
                state_d[wr_sel_q] = BUF_FULL;
                wr_cnt_d          = '0;
                wr_sel_d          = (wr_sel_q == LAST_BUF) ? '0 : wr_sel_q + 1'b1;
            end else begin
                state_d[wr_sel_q] = BUF_FILLING;
                wr_cnt_d          = wr_cnt_q + 1'b1;
            end
        end

        if (gnt_read) begin
            if (rd_last) begin
                state_d[rd_sel_q] = BUF_EMPTY;
                rd_cnt_d          = '0;
                rd_sel_d          = (rd_sel_q == LAST_BUF) ? '0 : rd_sel_q + 1'b1;
            end else begin
                state_d[rd_sel_q] = BUF_DRAINING;
                rd_cnt_d          = rd_cnt_q + 1'b1;
            end
        end
    end

    // Output logic for the grant cycle: the producer handshake and the
    // buffer-file write/read strobes are all combinational so the tile is
    // handed to the buffer file in the same cycle it is accepted.
    always_comb begin
        bus.in_ready        = gnt_write;
        bus.bf_write_enable = gnt_write;
        bus.bf_write_data   = wr_data;
        bus.bf_write_buffer = wr_sel_q;
        bus.bf_read_enable  = gnt_read;
        bus.bf_read_buffer  = rd_sel_q;
    end

    // Status counts are taken from the next state so that full_count and
    // idle line up with the registered buffer phases rather than lagging
    // them by a cycle.
    always_comb begin
        full_d      = '0;
        all_empty_d = 1'b1;
        for (int i = 0; i < BUFFER_COUNT; i++) begin
            if (state_d[i] == BUF_FULL) begin
                full_d = full_d + 1'b1;
            end
            if (state_d[i] != BUF_EMPTY) begin
                all_empty_d = 1'b0;
            end
        end
    end

    // Consumer-facing and status registers. The buffer file returns read
    // data one cycle after bf_read_enable, so out_valid/out_buf/out_last are
    // captured from the grant cycle to line up with that data. The done
    // pulses from the buffer file must arrive exactly one cycle after a
    // last-tile grant; any disagreement latches err until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_buf   <= '0;
            bus.out_last  <= 1'b0;
            full_count    <= '0;
            idle          <= 1'b1;
            err           <= 1'b0;
            wr_last_q     <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            bus.out_valid <= gnt_read;
            if (gnt_read) begin
                bus.out_buf <= rd_sel_q;
            end
            bus.out_last  <= gnt_read && rd_last;
            full_count    <= full_d;
            idle          <= all_empty_d && !gnt_read;
            wr_last_q     <= gnt_write && wr_last;
            rd_last_q     <= gnt_read && rd_last;
            if ((bus.bf_writing_done != wr_last_q) ||
                (bus.bf_reading_done != rd_last_q)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buffer_pingpong_sched.sv
// ---------------------------------------------------------------------------
// tb_buffer_pingpong_sched
// Directed bench for buffer_pingpong_sched with two buffers of four tiles.
// A small buffer-file model answers every fourth write/read strobe with a
// done pulse one cycle later, as a well-behaved buffer file would.
// ---------------------------------------------------------------------------
module tb_buffer_pingpong_sched;

    localparam int BUFFER_COUNT     = 2;
    localparam int TILE_WIDTH       = 256;
    localparam int TILES_PER_BUFFER = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] full_count;
    logic       idle;
    logic       err;

    logic inject_wr_done = 1'b0;
    logic wr_done_pulse;
    logic rd_done_pulse;
    int   bf_wr_tiles;
    int   bf_rd_tiles;

    int error_count = 0;
    int check_count = 0;

    buffer_pingpong_sched_if #(
        .BUFFER_COUNT (BUFFER_COUNT),
        .TILE_WIDTH   (TILE_WIDTH)
    ) bus ();

    buffer_pingpong_sched #(
        .BUFFER_COUNT     (BUFFER_COUNT),
        .TILE_WIDTH       (TILE_WIDTH),
        .TILES_PER_BUFFER (TILES_PER_BUFFER)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .full_count (full_count),
        .idle       (idle),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Buffer-file model: counts tiles on each side and pulses done one cycle
    // after the fourth strobe. It is reset together with the scheduler.
    always @(posedge clk) begin
        if (reset) begin
            bf_wr_tiles   <= 0;
            bf_rd_tiles   <= 0;
            wr_done_pulse <= 1'b0;
            rd_done_pulse <= 1'b0;
        end else begin
            wr_done_pulse <= 1'b0;
            rd_done_pulse <= 1'b0;
            if (bus.bf_write_enable) begin
                if (bf_wr_tiles == TILES_PER_BUFFER - 1) begin
                    wr_done_pulse <= 1'b1;
                    bf_wr_tiles   <= 0;
                end else begin
                    bf_wr_tiles <= bf_wr_tiles + 1;
                end
            end
            if (bus.bf_read_enable) begin
                if (bf_rd_tiles == TILES_PER_BUFFER - 1) begin
                    rd_done_pulse <= 1'b1;
                    bf_rd_tiles   <= 0;
                end else begin
                    bf_rd_tiles <= bf_rd_tiles + 1;
                end
            end
        end
    end

    assign bus.bf_writing_done = wr_done_pulse | inject_wr_done;
    assign bus.bf_reading_done = rd_done_pulse;

    task automatic checkOutput(input string tag,
                               input logic [TILE_WIDTH-1:0] actual,
                               input logic [TILE_WIDTH-1:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive producer/consumer inputs just after a clock edge and let the
    // combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [TILE_WIDTH-1:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        step();
        step();
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_out_buf", bus.out_buf, 1'b0);
        checkOutput("rst_out_last", bus.out_last, 1'b0);
        checkOutput("rst_full_count", full_count, 2'd0);
        checkOutput("rst_idle", idle, 1'b1);
        checkOutput("rst_err", err, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic [TILE_WIDTH-1:0] tile;
        logic                  exp_r;
        logic                  exp_last;
        logic                  rbuf;
        logic                  wbuf;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        $display("[TB] reset");
        doReset();

        // Fill buffer 0 with tiles A0..A3.
        $display("[TB] fill buffer 0");
        for (int i = 0; i < 4; i++) begin
            tile = 'hA0 + i;
            applyStimulus(1'b1, tile, 1'b0);
            checkOutput("fill0_in_ready", bus.in_ready, 1'b1);
            checkOutput("fill0_wr_en", bus.bf_write_enable, 1'b1);
            checkOutput("fill0_wr_buf", bus.bf_write_buffer, 1'b0);
            checkOutput("fill0_wr_data", bus.bf_write_data, tile);
            checkOutput("fill0_rd_en", bus.bf_read_enable, 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("fill0_full_count", full_count, 2'd1);
        checkOutput("fill0_idle", idle, 1'b0);
        step();
        checkOutput("fill0_err", err, 1'b0);

        // Producer and consumer both busy: reads and writes alternate,
        // starting with a read since the last grant was a write. The first
        // eight cycles drain buffer 0 / fill buffer 1, the next eight drain
        // buffer 1 / fill buffer 0.
        $display("[TB] alternating read/write");
        for (int k = 0; k < 16; k++) begin
            exp_r    = ((k % 2) == 0);
            exp_last = ((k % 8) == 6);
            rbuf     = (k < 8) ? 1'b0 : 1'b1;
            wbuf     = (k < 8) ? 1'b1 : 1'b0;
            tile     = 'hC0 + k;
            applyStimulus(1'b1, tile, 1'b1);
            checkOutput("alt_rd_en", bus.bf_read_enable, exp_r);
            checkOutput("alt_in_ready", bus.in_ready, !exp_r);
            if (exp_r) begin
                checkOutput("alt_rd_buf", bus.bf_read_buffer, rbuf);
            end else begin
                checkOutput("alt_wr_buf", bus.bf_write_buffer, wbuf);
            end
            step();
            checkOutput("alt_out_valid", bus.out_valid, exp_r);
            if (exp_r) begin
                checkOutput("alt_out_buf", bus.out_buf, rbuf);
                checkOutput("alt_out_last", bus.out_last, exp_last);
            end
        end

        // Drain buffer 0 with no producer.
        $display("[TB] drain buffer 0");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("drain_rd_en", bus.bf_read_enable, 1'b1);
            checkOutput("drain_rd_buf", bus.bf_read_buffer, 1'b0);
            checkOutput("drain_in_ready", bus.in_ready, 1'b0);
            step();
            checkOutput("drain_out_valid", bus.out_valid, 1'b1);
            checkOutput("drain_out_buf", bus.out_buf, 1'b0);
            checkOutput("drain_out_last", bus.out_last, (i == 3));
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("empty_no_read", bus.bf_read_enable, 1'b0);
        step();
        checkOutput("empty_out_valid", bus.out_valid, 1'b0);
        checkOutput("empty_idle", idle, 1'b1);
        checkOutput("empty_full_count", full_count, 2'd0);
        checkOutput("empty_err", err, 1'b0);

        // Fill both buffers with the consumer stalled; the ninth tile must
        // be refused.
        $display("[TB] fill both buffers");
        doReset();
        for (int i = 0; i < 8; i++) begin
            tile = 'hB0 + i;
            applyStimulus(1'b1, tile, 1'b0);
            checkOutput("both_in_ready", bus.in_ready, 1'b1);
            checkOutput("both_wr_buf", bus.bf_write_buffer, (i >= 4));
            checkOutput("both_rd_en", bus.bf_read_enable, 1'b0);
            step();
        end
        checkOutput("both_full_count", full_count, 2'd2);
        tile = 'hB8;
        applyStimulus(1'b1, tile, 1'b0);
        checkOutput("both_9th_in_ready", bus.in_ready, 1'b0);
        checkOutput("both_9th_wr_en", bus.bf_write_enable, 1'b0);
        step();
        checkOutput("both_err", err, 1'b0);

        // Spurious writing_done: err latches and stays set.
        $display("[TB] spurious writing_done");
        applyStimulus(1'b0, '0, 1'b0);
        inject_wr_done = 1'b1;
        step();
        inject_wr_done = 1'b0;
        checkOutput("err_set", err, 1'b1);
        step();
        step();
        checkOutput("err_sticky", err, 1'b1);

        // Reset in the middle of a fill throws the partial buffer away.
        $display("[TB] reset mid-fill");
        doReset();
        tile = 'hD0;
        applyStimulus(1'b1, tile, 1'b0);
        checkOutput("midrst_wr_buf", bus.bf_write_buffer, 1'b0);
        step();
        reset = 1'b1;
        tile  = 'hD1;
        applyStimulus(1'b1, tile, 1'b0);
        step();
        checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
        checkOutput("midrst_out_last", bus.out_last, 1'b0);
        checkOutput("midrst_full_count", full_count, 2'd0);
        checkOutput("midrst_idle", idle, 1'b1);
        checkOutput("midrst_err", err, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tile = 'hE0 + i;
            applyStimulus(1'b1, tile, 1'b0);
            checkOutput("refill_in_ready", bus.in_ready, 1'b1);
            checkOutput("refill_wr_buf", bus.bf_write_buffer, 1'b0);
            step();
            checkOutput("refill_full_count", full_count, (i == 3) ? 2'd1 : 2'd0);
        end
        applyStimulus(1'b0, '0, 1'b0);
        step();
        checkOutput("refill_err", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/buffer_pingpong_sched.md
BUFFER_PINGPONG_SCHED -- requirements
Module: buffer_pingpong_sched

Interface
REQ-001 SHALL have parameter BUFFER_COUNT, default 2, number of buffers scheduled in ping-pong order.
REQ-002 SHALL have parameter TILE_WIDTH, default 256, bits per tile.
REQ-003 SHALL have parameter TILES_PER_BUFFER, default 4, tiles per full buffer.
REQ-004 SHALL have ports: clk in 1, clock; reset in 1, synchronous active-high reset.
REQ-005 SHALL have producer ports: in_valid in 1, tile offered; in_data in TILE_WIDTH, tile; in_ready out 1, tile accepted this cycle.
REQ-006 SHALL have consumer ports: out_ready in 1, consumer can take a tile; out_valid out 1, tile on buffer-file read_data; out_buf out $clog2(BUFFER_COUNT), source buffer; out_last out 1, final tile of buffer.
REQ-007 SHALL have buffer-file ports: bf_write_enable out 1; bf_write_data out TILE_WIDTH; bf_write_buffer out $clog2(BUFFER_COUNT); bf_read_enable out 1; bf_read_buffer out $clog2(BUFFER_COUNT); bf_writing_done in 1; bf_reading_done in 1.
REQ-008 SHALL have status ports: full_count out $clog2(BUFFER_COUNT+1), buffers in FULL; idle out 1, all buffers EMPTY and no read in flight; err out 1, sticky protocol error.

Function
REQ-009 SHALL keep per-buffer state EMPTY, FILLING, FULL, DRAINING.
REQ-010 SHALL keep wr_sel (fill target), rd_sel (drain target), wr_cnt, rd_cnt (tile counters 0..TILES_PER_BUFFER-1).
REQ-011 Write eligible SHALL be in_valid and state[wr_sel] in {EMPTY, FILLING}.
REQ-012 Read eligible SHALL be out_ready and state[rd_sel] in {FULL, DRAINING}.
REQ-013 Only one of write/read SHALL be granted per cycle; if both eligible, grant opposite of last grant (toggle bit, initial write-first).
REQ-014 On write grant: in_ready=1, bf_write_enable=1, bf_write_data=in_data, bf_write_buffer=wr_sel, all combinational same cycle.
REQ-015 On write grant: EMPTY->FILLING; wr_cnt increments; at wr_cnt=TILES_PER_BUFFER-1 state->FULL, wr_cnt->0, wr_sel->(wr_sel+1) mod BUFFER_COUNT.
REQ-016 On read grant: bf_read_enable=1, bf_read_buffer=rd_sel; FULL->DRAINING; rd_cnt increments; at last tile state->EMPTY, rd_cnt->0, rd_sel advances mod BUFFER_COUNT.
REQ-017 out_valid SHALL assert exactly 1 cycle after each read grant, with out_buf/out_last registered from grant cycle.
REQ-018 Buffer freed by last read SHALL be write-eligible the next cycle, not the same cycle.
REQ-019 With all buffers FULL, in_ready=0; with none FULL/DRAINING, no read issued regardless of out_ready.
REQ-020 err SHALL set when bf_writing_done high but previous cycle was not a last-tile write grant, or absent when it was; identical rule for bf_reading_done vs last-tile read grant.
REQ-021 full_count SHALL be registered count of FULL buffers; idle registered.
REQ-022 No grant SHALL occur when neither side eligible; bf_*_enable default 0.

Reset
REQ-023 On reset: all states EMPTY, wr_sel=rd_sel=0, counters 0, toggle=write-first, out_valid=0, out_buf=0, out_last=0, full_count=0, idle=1, err=0.
REQ-024 Reset mid-fill or mid-drain SHALL discard progress; buffer file SHALL be reset by the system in the same cycle (tile indices shared).

Structure
REQ-025 Buffer state enum and default parameters SHALL live in a shared package (tinyml_buf_pkg).
REQ-026 Arbiter toggle SHALL be a sub-module rw_arbiter (2 requests, alternating priority, one-hot grant).

Verification
REQ-027 Reset, then in_valid for 4 cycles with tiles 0xA0..0xA3 -> bf_write_buffer=0 each, buffer0 FULL, full_count=1, wr_sel=1.
REQ-028 8 tiles in, out_ready=0 -> buffers 0,1 FULL, in_ready=0 on 9th tile, full_count=2.
REQ-029 Buffer0 FULL, in_valid and out_ready held high -> grants alternate R,W,R,W; out_valid 1 cycle after each R; out_last on 4th read, out_buf=0.
REQ-030 Drain buffer0 while FILLING buffer1 -> buffer0 EMPTY, next fill order 1 then 0, reads follow fill order.
REQ-031 Inject bf_writing_done with no preceding last write -> err=1 next cycle and stays until reset.
REQ-032 Reset asserted during 2nd tile of a fill -> all outputs at REQ-023 values next cycle, next write targets buffer0 tile 0.
